// File: rtl/shift_register_reader_if.sv
// Bus bundle between the shift-register reader and its user/external 74HC165 pins.
// slave = the reader itself, master = the logic driving it.
interface shift_register_reader_if #(
  parameter int WIDTH = 8
);
  logic             i_clk_stb;
  logic             i_start_stb;
  logic             o_busy;
  logic             i_serial_data;
  logic             o_serial_load_n;
  logic             o_serial_clk;
  logic [WIDTH-1:0] o_parallel_data;
  logic             o_data_valid;

  modport slave (
    input  i_clk_stb, i_start_stb, i_serial_data,
    output o_busy, o_serial_load_n, o_serial_clk, o_parallel_data, o_data_valid
  );

  modport master (
    output i_clk_stb, i_start_stb, i_serial_data,
    input  o_busy, o_serial_load_n, o_serial_clk, o_parallel_data, o_data_valid
  );
endinterface

// File: rtl/shift_register_reader.sv
// Serial-in/parallel-out reader for a 74HC165-style parallel-load shift register.
// state    | meaning
// IDLE     | waiting for start, load_n=1, sclk=0
// LOAD     | load_n held low for one strobe period
// SAMPLE   | sclk low, capture Q7 on next strobe
// CLK_HIGH | sclk high, external register shifts on the rising edge
module shift_register_reader #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  shift_register_reader_if.slave bus
);
  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SAMPLE, CLK_HIGH} state_e;

  state_e           state_q, state_d;
  logic             load_n_q, load_n_d;
  logic             sclk_q, sclk_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= IDLE;
      load_n_q <= 1'b1;
      sclk_q   <= 1'b0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      shreg_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      load_n_q <= load_n_d;
      sclk_q   <= sclk_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    load_n_d = load_n_q;
    sclk_d   = sclk_q;
    busy_d   = busy_q;
    valid_d  = 1'b0;
    data_d   = data_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;

    unique case (state_q)
      IDLE: begin
        // A strobe coinciding with start is ignored so load_n spans a full period.
        if (bus.i_start_stb) begin
          state_d  = LOAD;
          load_n_d = 1'b0;
          busy_d   = 1'b1;
        end
      end
      LOAD: begin
        if (bus.i_clk_stb) begin
          state_d  = SAMPLE;
          load_n_d = 1'b1;
          cnt_d    = '0;
        end
      end
      SAMPLE: begin
        if (bus.i_clk_stb) begin
          if (MSB_FIRST) shreg_d = {shreg_q[WIDTH-2:0], bus.i_serial_data};
          else           shreg_d = {bus.i_serial_data, shreg_q[WIDTH-1:1]};
          if (cnt_q == LAST_BIT) begin
            state_d = IDLE;
            data_d  = shreg_d;
            valid_d = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d = CLK_HIGH;
            sclk_d  = 1'b1;
          end
        end
      end
      CLK_HIGH: begin
        if (bus.i_clk_stb) begin
          state_d = SAMPLE;
          sclk_d  = 1'b0;
          cnt_d   = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.o_busy          = busy_q;
  assign bus.o_serial_load_n = load_n_q;
  assign bus.o_serial_clk    = sclk_q;
  assign bus.o_parallel_data = data_q;
  assign bus.o_data_valid    = valid_q;
endmodule

// File: tb/tb_shift_register_reader.sv
// Scoreboard bench: three readers (8/MSB-first, 8/LSB-first, 16/MSB-first) each
// fed by a behavioural 165 model; expected words are queued at start, checked on valid.
module tb_shift_register_reader;
  logic i_clk = 1'b0;
  logic i_reset_n = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_pass   = 0;

  shift_register_reader_if #(.WIDTH(8))  ifa ();
  shift_register_reader_if #(.WIDTH(8))  ifb ();
  shift_register_reader_if #(.WIDTH(16)) ifc ();

  shift_register_reader #(.WIDTH(8),  .MSB_FIRST(1'b1)) u_a (.i_clk(i_clk), .i_reset_n(i_reset_n), .bus(ifa));
  shift_register_reader #(.WIDTH(8),  .MSB_FIRST(1'b0)) u_b (.i_clk(i_clk), .i_reset_n(i_reset_n), .bus(ifb));
  shift_register_reader #(.WIDTH(16), .MSB_FIRST(1'b1)) u_c (.i_clk(i_clk), .i_reset_n(i_reset_n), .bus(ifc));

  logic stb = 1'b0;
  bit   stb_en = 1'b1;
  logic start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
  logic [15:0] pre_a = '0, pre_b = '0, pre_c = '0;
  logic [15:0] sra = '0, srb = '0, src = '0;
  logic sclk_pa = 1'b0, sclk_pb = 1'b0, sclk_pc = 1'b0;
  int edges_a = 0, edges_b = 0, edges_c = 0;

  assign ifa.i_clk_stb = stb;
  assign ifb.i_clk_stb = stb;
  assign ifc.i_clk_stb = stb;
  assign ifa.i_start_stb = start_a;
  assign ifb.i_start_stb = start_b;
  assign ifc.i_start_stb = start_c;
  assign ifa.i_serial_data = sra[7];
  assign ifb.i_serial_data = srb[7];
  assign ifc.i_serial_data = src[15];

  logic [15:0] q_a[$], q_b[$], q_c[$];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Behavioural 165s: parallel load while load_n low, shift on sclk rise.
  always @(posedge i_clk) begin
    if (!ifa.o_serial_load_n) begin sra <= pre_a; edges_a <= 0; end
    else if (ifa.o_serial_clk && !sclk_pa) begin sra <= sra << 1; edges_a <= edges_a + 1; end
    if (!ifb.o_serial_load_n) begin srb <= pre_b; edges_b <= 0; end
    else if (ifb.o_serial_clk && !sclk_pb) begin srb <= srb << 1; edges_b <= edges_b + 1; end
    if (!ifc.o_serial_load_n) begin src <= pre_c; edges_c <= 0; end
    else if (ifc.o_serial_clk && !sclk_pc) begin src <= src << 1; edges_c <= edges_c + 1; end
    sclk_pa <= ifa.o_serial_clk;
    sclk_pb <= ifb.o_serial_clk;
    sclk_pc <= ifc.o_serial_clk;
  end

  initial begin
    int ph = 0;
    forever begin
      @(negedge i_clk);
      stb = stb_en && (ph == 0);
      ph = (ph + 1) % 4;
    end
  end

  // Monitor
  initial begin
    logic [15:0] exp;
    bit pva = 0, pvb = 0, pvc = 0;
    forever begin
      @(negedge i_clk);
      if (i_reset_n) begin
        if (ifa.o_data_valid) begin
          if (q_a.size() == 0) check("a_unexpected_valid", 1, 0);
          else begin exp = q_a.pop_front(); check("a_word", {24'd0, ifa.o_parallel_data}, {24'd0, exp[7:0]}); end
          check("a_busy_at_valid", ifa.o_busy, 0);
          check("a_sclk_edges", edges_a, 7);
          check("a_valid_one_cycle", pva, 0);
        end
        if (ifb.o_data_valid) begin
          if (q_b.size() == 0) check("b_unexpected_valid", 1, 0);
          else begin exp = q_b.pop_front(); check("b_word", {24'd0, ifb.o_parallel_data}, {24'd0, exp[7:0]}); end
          check("b_busy_at_valid", ifb.o_busy, 0);
          check("b_sclk_edges", edges_b, 7);
          check("b_valid_one_cycle", pvb, 0);
        end
        if (ifc.o_data_valid) begin
          if (q_c.size() == 0) check("c_unexpected_valid", 1, 0);
          else begin exp = q_c.pop_front(); check("c_word", {16'd0, ifc.o_parallel_data}, {16'd0, exp}); end
          check("c_busy_at_valid", ifc.o_busy, 0);
          check("c_sclk_edges", edges_c, 15);
          check("c_valid_one_cycle", pvc, 0);
        end
      end
      pva = ifa.o_data_valid;
      pvb = ifb.o_data_valid;
      pvc = ifc.o_data_valid;
    end
  end

  task automatic start(int which, logic [15:0] pre, logic [15:0] exp, bit push, bit align);
    int n = 0;
    @(negedge i_clk); #1;
    if (align) while (!stb && n < 20) begin @(negedge i_clk); #1; n++; end
    case (which)
      0: begin pre_a = pre; start_a = 1'b1; if (push) q_a.push_back(exp); end
      1: begin pre_b = pre; start_b = 1'b1; if (push) q_b.push_back(exp); end
      default: begin pre_c = pre; start_c = 1'b1; if (push) q_c.push_back(exp); end
    endcase
    @(negedge i_clk); #1;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
  endtask

  task automatic wait_done(string name);
    int n = 0;
    while ((q_a.size() + q_b.size() + q_c.size() != 0 || ifa.o_busy || ifb.o_busy || ifc.o_busy)
           && n < 2000) begin
      @(negedge i_clk); n++;
    end
    if (n >= 2000) check({name, "_timeout"}, 1, 0);
    repeat (3) @(negedge i_clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int diffs;
    logic [11:0] snap;

    repeat (3) @(negedge i_clk);
    check("rst_load_n", ifa.o_serial_load_n, 1);
    check("rst_sclk",   ifa.o_serial_clk, 0);
    check("rst_busy",   ifa.o_busy, 0);
    check("rst_data",   ifa.o_parallel_data, 0);
    check("rst_valid",  ifa.o_data_valid, 0);
    i_reset_n = 1'b1;

    start(0, 16'h00A5, 16'h00A5, 1, 0);
    check("t1_busy_after_start", ifa.o_busy, 1);
    wait_done("t1");
    check("t1_data_holds", ifa.o_parallel_data, 8'hA5);

    start(1, 16'h0001, 16'h0080, 1, 0);
    wait_done("t2_lsb");
    start(2, 16'h1234, 16'h1234, 1, 0);
    wait_done("t2_w16");

    // Start held high for the whole transfer: only one transfer must occur.
    @(negedge i_clk); #1;
    pre_a = 16'h005A; q_a.push_back(16'h005A); start_a = 1'b1;
    n = 0;
    while (!ifa.o_data_valid && n < 500) begin @(negedge i_clk); n++; end
    if (n >= 500) check("t3_valid_timeout", 1, 0);
    start_a = 1'b0;
    n = 0;
    repeat (60) begin @(negedge i_clk); if (ifa.o_busy) n++; end
    check("t3_no_restart_busy_cycles", n, 0);
    wait_done("t3");

    start(0, 16'h00C3, 16'h00C3, 1, 1);
    n = 0;
    while (!ifa.o_serial_load_n && n < 50) begin n++; @(negedge i_clk); #1; end
    check("t4_load_n_low_cycles", n, 4);
    n = 0;
    while (!ifa.o_data_valid && n < 500) begin @(negedge i_clk); n++; end
    if (n >= 500) check("t4_valid_timeout", 1, 0);
    #1;
    pre_a = 16'h0096; q_a.push_back(16'h0096); start_a = 1'b1;
    @(negedge i_clk); #1;
    start_a = 1'b0;
    check("t4_b2b_accepted", ifa.o_busy, 1);
    wait_done("t4");

    start(0, 16'h00FF, 16'h0000, 0, 0);
    n = 0;
    while (!(edges_a == 3 && !ifa.o_serial_clk && ifa.o_busy) && n < 500) begin @(negedge i_clk); n++; end
    if (n >= 500) check("t5_reach_timeout", 1, 0);
    i_reset_n = 1'b0;
    #1;
    check("t5_load_n", ifa.o_serial_load_n, 1);
    check("t5_sclk",   ifa.o_serial_clk, 0);
    check("t5_busy",   ifa.o_busy, 0);
    check("t5_data",   ifa.o_parallel_data, 0);
    check("t5_valid",  ifa.o_data_valid, 0);
    repeat (2) @(negedge i_clk);
    i_reset_n = 1'b1;
    start(0, 16'h003C, 16'h003C, 1, 0);
    wait_done("t5");

    start(1, 16'h00B4, 16'h002D, 1, 0);
    n = 0;
    while (edges_b != 2 && n < 500) begin @(negedge i_clk); n++; end
    if (n >= 500) check("t6_reach_timeout", 1, 0);
    stb_en = 1'b0;
    repeat (2) @(negedge i_clk);
    snap = {ifb.o_busy, ifb.o_serial_load_n, ifb.o_serial_clk, ifb.o_data_valid, ifb.o_parallel_data};
    diffs = 0;
    repeat (100) begin
      @(negedge i_clk);
      if ({ifb.o_busy, ifb.o_serial_load_n, ifb.o_serial_clk, ifb.o_data_valid, ifb.o_parallel_data} !== snap)
        diffs++;
    end
    check("t6_stall_changes", diffs, 0);
    check("t6_stall_busy", ifb.o_busy, 1);
    stb_en = 1'b1;
    wait_done("t6");

    check("sb_drained", q_a.size() + q_b.size() + q_c.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
